// File: rtl/fibo_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : fibo_controller_if
//  Description : Handshake and datapath-control bundle between the Fibonacci
//                control FSM and its environment (requester + datapath).
//  Revision    : 1.0  initial release
// ============================================================================
interface fibo_controller_if #(
  parameter int size = 4
);
  // request side
  logic            start;
  logic [size-1:0] n;
  // datapath status
  logic            zero_flag;
  // datapath controls
  logic [1:0]      wrt_addr;
  logic            wrt_en;
  logic            load_data;
  logic [1:0]      rd_addr1;
  logic [1:0]      rd_addr2;
  logic [size-2:0] alu_opcode;
  logic [size-1:0] count;
  // run status
  logic            busy;
  logic            done;

  // Environment side: issues requests, reports datapath status
  modport master (
    output start, n, zero_flag,
    input  wrt_addr, wrt_en, load_data, rd_addr1, rd_addr2,
           alu_opcode, count, busy, done
  );

  // Controller side
  modport slave (
    input  start, n, zero_flag,
    output wrt_addr, wrt_en, load_data, rd_addr1, rd_addr2,
           alu_opcode, count, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/fibo_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fibo_controller
//  Description : Moore control FSM sequencing a register-file/ALU datapath to
//                compute F(n) mod 2^size. R0=1, R1/R2 = Fibonacci pair,
//                R3 = remaining iteration count.
//  Revision    : 1.0  initial release
// ============================================================================
module fibo_controller #(
  parameter int              size    = 4,
  parameter logic [size-2:0] OP_ADD  = 3'b001,
  parameter logic [size-2:0] OP_SUB  = 3'b010,
  parameter logic [size-2:0] OP_PASS = 3'b110
) (
  input  wire logic         Clk,
  input  wire logic         Rst,
  fibo_controller_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_INIT0 = 4'd1,
    S_INIT1 = 4'd2,
    S_INIT2 = 4'd3,
    S_INIT3 = 4'd4,
    S_TEST  = 4'd5,
    S_ADD   = 4'd6,
    S_DEC   = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t          state_q, state_d;
  logic            old_sel_q, old_sel_d;
  logic [size-1:0] n_reg_q, n_reg_d;

  logic [1:0]      wrt_addr_q, wrt_addr_d;
  logic            wrt_en_q, wrt_en_d;
  logic            load_data_q, load_data_d;
  logic [1:0]      rd_addr1_q, rd_addr1_d;
  logic [1:0]      rd_addr2_q, rd_addr2_d;
  logic [size-2:0] alu_opcode_q, alu_opcode_d;
  logic [size-1:0] count_q, count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      old_addr;

  // Next-state logic: run sequencing, n latch, and OLD-register toggle
  always_comb begin
    state_d   = state_q;
    old_sel_d = old_sel_q;
    n_reg_d   = n_reg_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_reg_d   = bus.n;
          old_sel_d = 1'b0;
          state_d   = S_INIT0;
        end
      end
      S_INIT0: state_d = S_INIT1;
      S_INIT1: state_d = S_INIT2;
      S_INIT2: state_d = S_INIT3;
      S_INIT3: state_d = S_TEST;
      S_TEST:  state_d = bus.zero_flag ? S_DONE : S_ADD;
      S_ADD: begin
        // the register just overwritten becomes the "new" one
        old_sel_d = ~old_sel_q;
        state_d   = S_DEC;
      end
      S_DEC:   state_d = S_TEST;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, so the registered outputs are a
  // pure function of the state register and old_sel in every cycle
  always_comb begin
    old_addr     = old_sel_d ? 2'd2 : 2'd1;
    wrt_addr_d   = 2'd0;
    wrt_en_d     = 1'b0;
    load_data_d  = 1'b0;
    rd_addr1_d   = 2'd0;
    rd_addr2_d   = 2'd0;
    alu_opcode_d = OP_PASS;
    count_d      = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    case (state_d)
      S_INIT0: begin
        wrt_addr_d  = 2'd0;
        wrt_en_d    = 1'b1;
        load_data_d = 1'b1;
        count_d     = size'(1);
        busy_d      = 1'b1;
      end
      S_INIT1: begin
        wrt_addr_d  = 2'd1;
        wrt_en_d    = 1'b1;
        load_data_d = 1'b1;
        count_d     = '0;
        busy_d      = 1'b1;
      end
      S_INIT2: begin
        wrt_addr_d  = 2'd2;
        wrt_en_d    = 1'b1;
        load_data_d = 1'b1;
        count_d     = size'(1);
        busy_d      = 1'b1;
      end
      S_INIT3: begin
        wrt_addr_d  = 2'd3;
        wrt_en_d    = 1'b1;
        load_data_d = 1'b1;
        count_d     = n_reg_d;
        busy_d      = 1'b1;
      end
      S_TEST: begin
        rd_addr1_d = 2'd3;
        busy_d     = 1'b1;
      end
      S_ADD: begin
        wrt_addr_d   = old_addr;
        wrt_en_d     = 1'b1;
        rd_addr1_d   = 2'd1;
        rd_addr2_d   = 2'd2;
        alu_opcode_d = OP_ADD;
        busy_d       = 1'b1;
      end
      S_DEC: begin
        wrt_addr_d   = 2'd3;
        wrt_en_d     = 1'b1;
        rd_addr1_d   = 2'd3;
        rd_addr2_d   = 2'd0;
        alu_opcode_d = OP_SUB;
        busy_d       = 1'b1;
      end
      S_DONE: begin
        rd_addr1_d = old_addr;
        busy_d     = 1'b1;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // State, latched operands and registered Moore outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      old_sel_q    <= 1'b0;
      n_reg_q      <= '0;
      wrt_addr_q   <= 2'd0;
      wrt_en_q     <= 1'b0;
      load_data_q  <= 1'b0;
      rd_addr1_q   <= 2'd0;
      rd_addr2_q   <= 2'd0;
      alu_opcode_q <= OP_PASS;
      count_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      old_sel_q    <= old_sel_d;
      n_reg_q      <= n_reg_d;
      wrt_addr_q   <= wrt_addr_d;
      wrt_en_q     <= wrt_en_d;
      load_data_q  <= load_data_d;
      rd_addr1_q   <= rd_addr1_d;
      rd_addr2_q   <= rd_addr2_d;
      alu_opcode_q <= alu_opcode_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.wrt_addr   = wrt_addr_q;
  assign bus.wrt_en     = wrt_en_q;
  assign bus.load_data  = load_data_q;
  assign bus.rd_addr1   = rd_addr1_q;
  assign bus.rd_addr2   = rd_addr2_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.count      = count_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fibo_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fibo_controller
//  Description : Bench for fibo_controller with a behavioural datapath and a
//                Fibonacci reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fibo_controller;
  localparam int         SIZE    = 4;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b110;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  fibo_controller_if #(.size(SIZE)) bus ();

  fibo_controller #(.size(SIZE)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Behavioural datapath: 4-entry register file plus ALU
  logic [3:0] rf [4];
  logic [3:0] alu_y;

  // ALU result from the two read ports
  always_comb begin
    alu_y = rf[bus.rd_addr1];
    case (bus.alu_opcode)
      OP_ADD:  alu_y = rf[bus.rd_addr1] + rf[bus.rd_addr2];
      OP_SUB:  alu_y = rf[bus.rd_addr1] - rf[bus.rd_addr2];
      default: alu_y = rf[bus.rd_addr1];
    endcase
  end
  assign bus.zero_flag = (alu_y == 4'd0);

  // Register-file write port
  always @(posedge Clk) begin
    if (bus.wrt_en) rf[bus.wrt_addr] <= bus.load_data ? bus.count : alu_y;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: F(k) mod 16 by plain iteration
  function automatic logic [3:0] fib_mod(input int k);
    int a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return 4'(a % 16);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  bus.busy,       0);
    check({tag, ".done"},  bus.done,       0);
    check({tag, ".wen"},   bus.wrt_en,     0);
    check({tag, ".load"},  bus.load_data,  0);
    check({tag, ".waddr"}, bus.wrt_addr,   0);
    check({tag, ".rd1"},   bus.rd_addr1,   0);
    check({tag, ".rd2"},   bus.rd_addr2,   0);
    check({tag, ".op"},    bus.alu_opcode, OP_PASS);
    check({tag, ".count"}, bus.count,      0);
  endtask

  // Present a request; returns just after the accept edge
  task automatic start_run(input logic [3:0] nv, input bit hold, input bit scramble);
    @(posedge Clk);
    #1;
    bus.start = 1'b1;
    bus.n     = nv;
    @(posedge Clk);
    #1;
    if (!hold) bus.start = 1'b0;
    if (scramble) bus.n = 4'($urandom);
  endtask

  // Follow one run from the accept edge and compare against the model
  task automatic observe(input logic [3:0] nv, input bit disturb, input string tag);
    int exp_c, done_c, adds, decs, alt_bad, busy_bad;
    logic [3:0] data;
    exp_c    = 6 + 3 * int'(nv);
    done_c   = -1;
    adds     = 0;
    decs     = 0;
    alt_bad  = 0;
    busy_bad = 0;
    data     = 4'd0;
    for (int i = 1; i <= exp_c + 20; i++) begin
      @(negedge Clk);
      if (!bus.busy) busy_bad++;
      if (bus.wrt_en && !bus.load_data && bus.alu_opcode == OP_ADD) begin
        if (bus.wrt_addr != ((adds % 2 == 0) ? 2'd1 : 2'd2)) alt_bad++;
        adds++;
      end
      if (bus.wrt_en && bus.alu_opcode == OP_SUB) decs++;
      if (bus.done) begin
        done_c = i;
        data   = alu_y;
        break;
      end
      if (disturb && i == 3) begin
        bus.start = 1'b1;
        bus.n     = 4'd9;
      end
      if (disturb && i == 5) bus.start = 1'b0;
    end
    check({tag, ".done_cycle"}, done_c,   exp_c);
    check({tag, ".data"},       data,     fib_mod(int'(nv)));
    check({tag, ".adds"},       adds,     nv);
    check({tag, ".decs"},       decs,     nv);
    check({tag, ".alt"},        alt_bad,  0);
    check({tag, ".busy_run"},   busy_bad, 0);
    @(negedge Clk);
    check({tag, ".done_pulse"}, bus.done, 0);
    check({tag, ".busy_after"}, bus.busy, 0);
  endtask

  initial begin
    logic [3:0] rn;
    int         guard;
    bus.start = 1'b0;
    bus.n     = 4'd0;

    // reset state
    repeat (3) @(negedge Clk);
    check_idle("reset");
    Rst = 1'b0;
    @(negedge Clk);
    check_idle("idle");

    start_run(4'd0, 1'b0, 1'b1);
    observe(4'd0, 1'b0, "n0");

    start_run(4'd7, 1'b0, 1'b1);
    observe(4'd7, 1'b0, "n7");

    start_run(4'd10, 1'b0, 1'b1);
    observe(4'd10, 1'b0, "n10");

    // start pulsed and n changed mid-run
    start_run(4'd5, 1'b0, 1'b0);
    observe(4'd5, 1'b1, "n5_dist");

    // start held high: new run accepted in the IDLE cycle after DONE
    start_run(4'd2, 1'b1, 1'b0);
    observe(4'd2, 1'b0, "hold1");
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
    observe(4'd2, 1'b0, "hold2");

    // asynchronous reset in the middle of an ADD
    start_run(4'd6, 1'b0, 1'b0);
    guard = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (bus.wrt_en && bus.alu_opcode == OP_ADD) guard++;
      if (guard == 2) break;
    end
    check("rst.reached_add", guard, 2);
    Rst = 1'b1;
    #1;
    check_idle("rst_async");
    #2;
    Rst = 1'b0;
    start_run(4'd1, 1'b0, 1'b1);
    observe(4'd1, 1'b0, "after_rst_n1");

    // random indices
    for (int r = 0; r < 8; r++) begin
      rn = 4'($urandom_range(0, 15));
      start_run(rn, 1'b0, 1'b1);
      observe(rn, 1'b0, $sformatf("rand%0d_n%0d", r, rn));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
